// File: rtl/shift_arbiter_if.sv
// Bundle of the requester, shifter and response signals around shift_arbiter.
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req0_*/req1_*       : operand, shift amount and shift type of each requester
//   sh_a/sh_shamt/sh_type, sh_r : connection to the shared combinational shifter
//   resp_valid/resp_ready, resp_id, resp_r : result handshake towards the consumer
// The slave modport is the arbiter's view; master is the surrounding system.
interface shift_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a;
    logic [4:0]  req0_shamt;
    logic [1:0]  req0_type;
    logic [31:0] req1_a;
    logic [4:0]  req1_shamt;
    logic [1:0]  req1_type;
    logic [31:0] sh_a;
    logic [4:0]  sh_shamt;
    logic [1:0]  sh_type;
    logic [31:0] sh_r;
    logic        resp_valid;
    logic        resp_id;
    logic [31:0] resp_r;
    logic        resp_ready;

    modport slave (
        input  req_valid, req0_a, req0_shamt, req0_type,
        input  req1_a, req1_shamt, req1_type, sh_r, resp_ready,
        output req_ready, sh_a, sh_shamt, sh_type, resp_valid, resp_id, resp_r
    );

    modport master (
        output req_valid, req0_a, req0_shamt, req0_type,
        output req1_a, req1_shamt, req1_type, sh_r, resp_ready,
        input  req_ready, sh_a, sh_shamt, sh_type, resp_valid, resp_id, resp_r
    );
endinterface

// File: rtl/shift_arbiter.sv
// Shares one combinational shifter between two requesters (0: EX-stage ALU
// shift path, 1: secondary multi-cycle helper). One transaction is in flight
// at a time: the winner's operands are latched into the sh_* registers, the
// shifter result is captured one cycle later and returned with a handshake.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : shift_arbiter_if.slave (requests, shifter link, response)
//   dbg_state : current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A request holds req_valid and its operands stable until its
// req_ready bit is seen; the arbiter holds resp_valid, resp_id and resp_r
// stable until resp_ready is seen. req_ready is combinational from req_valid
// and state and is never asserted for a requester whose req_valid is low.
//
// Parameter PRIO_MODE: 0 = round-robin, 1 = requester 0 always wins.
module shift_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    shift_arbiter_if.slave   bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prefer_q, prefer_d;     // requester favoured on a tie (round-robin)
    logic        id_q, id_d;             // owner of the transaction in flight
    logic [31:0] sh_a_q, sh_a_d;
    logic [4:0]  sh_shamt_q, sh_shamt_d;
    logic [1:0]  sh_type_q, sh_type_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [31:0] resp_r_q, resp_r_d;

    logic        window;
    logic [1:0]  grant;
    logic        accept;
    logic        grant_id;

    // The window also opens in DONE on the response handshake cycle so a
    // waiting request is taken back-to-back with the result leaving.
    always_comb begin
        window = (state_q == IDLE) || ((state_q == DONE) && bus.resp_ready);
        grant  = 2'b00;
        if (window && !rst) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ((PRIO_MODE == 1) || !prefer_q) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        accept   = |grant;
        grant_id = grant[1];
    end

    always_comb begin
        state_d      = state_q;
        prefer_d     = prefer_q;
        id_d         = id_q;
        sh_a_d       = sh_a_q;
        sh_shamt_d   = sh_shamt_q;
        sh_type_d    = sh_type_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_r_d     = resp_r_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                resp_r_d     = bus.sh_r;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = accept ? BUSY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shift type is forwarded untouched; encoding 11 is the shifter's business.
        if (accept) begin
            id_d       = grant_id;
            prefer_d   = ~grant_id;
            sh_a_d     = grant_id ? bus.req1_a     : bus.req0_a;
            sh_shamt_d = grant_id ? bus.req1_shamt : bus.req0_shamt;
            sh_type_d  = grant_id ? bus.req1_type  : bus.req0_type;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prefer_q     <= 1'b0;
            id_q         <= 1'b0;
            sh_a_q       <= '0;
            sh_shamt_q   <= '0;
            sh_type_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_r_q     <= '0;
        end else begin
            state_q      <= state_d;
            prefer_q     <= prefer_d;
            id_q         <= id_d;
            sh_a_q       <= sh_a_d;
            sh_shamt_q   <= sh_shamt_d;
            sh_type_q    <= sh_type_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_r_q     <= resp_r_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.sh_a       = sh_a_q;
    assign bus.sh_shamt   = sh_shamt_q;
    assign bus.sh_type    = sh_type_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_r     = resp_r_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: one round-robin instance (bus0) and one
// fixed-priority instance (bus1), each connected to a behavioural shifter.
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_arbiter_if bus0 ();
    shift_arbiter_if bus1 ();
    logic [1:0] dbg0, dbg1;

    shift_arbiter #(.PRIO_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0));
    shift_arbiter #(.PRIO_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));

    int errors;
    int checks;
    int next_pref0;                 // requester the round-robin instance should favour on a tie
    logic [32:0] exp_q[$];          // {id, result}

    // The external shared shifter.
    function automatic logic [31:0] shifter(input logic [31:0] a, input logic [4:0] s, input logic [1:0] t);
        case (t)
            2'b01:   return a << s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return a >> s;
        endcase
    endfunction

    // Expected result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s, input logic [1:0] t);
        logic [63:0] wide;
        if (t == 2'b01) begin
            wide = {32'd0, a} * (64'd1 << s);
            return wide[31:0];
        end
        wide = (t == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        wide = wide >> s;
        return wide[31:0];
    endfunction

    assign bus0.sh_r = shifter(bus0.sh_a, bus0.sh_shamt, bus0.sh_type);
    assign bus1.sh_r = shifter(bus1.sh_a, bus1.sh_shamt, bus1.sh_type);

    // ---------------- driver tasks ----------------
    task automatic drive_req0(input logic [31:0] a, input logic [4:0] s, input logic [1:0] t);
        bus0.req0_a = a; bus0.req0_shamt = s; bus0.req0_type = t;
    endtask

    task automatic drive_req1(input logic [31:0] a, input logic [4:0] s, input logic [1:0] t);
        bus0.req1_a = a; bus0.req1_shamt = s; bus0.req1_type = t;
    endtask

    task automatic drive_rand_bus1(input logic which);
        if (which) begin
            bus1.req1_a = $urandom; bus1.req1_shamt = 5'($urandom_range(0, 31)); bus1.req1_type = 2'($urandom_range(0, 3));
        end else begin
            bus1.req0_a = $urandom; bus1.req0_shamt = 5'($urandom_range(0, 31)); bus1.req0_type = 2'($urandom_range(0, 3));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        bus0.req_valid = 2'b11; bus1.req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus0.req_ready !== 2'b00 || bus1.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready: got %b/%b want 00/00", bus0.req_ready, bus1.req_ready);
        end
        checks++;
        if ({bus0.resp_valid, bus0.resp_id, bus0.resp_r} !== 34'd0 || {bus1.resp_valid, bus1.resp_id, bus1.resp_r} !== 34'd0) begin
            errors++;
            $display("FAIL reset_resp: got v=%b id=%b r=%h want 0/0/0", bus0.resp_valid, bus0.resp_id, bus0.resp_r);
        end
        checks++;
        if ({bus0.sh_a, bus0.sh_shamt, bus0.sh_type} !== 39'd0 || {bus1.sh_a, bus1.sh_shamt, bus1.sh_type} !== 39'd0) begin
            errors++;
            $display("FAIL reset_sh: got a=%h s=%0d t=%b want 0", bus0.sh_a, bus0.sh_shamt, bus0.sh_type);
        end
        @(posedge clk); #1;
        bus0.req_valid = 2'b00; bus1.req_valid = 2'b00;
        rst = 1'b0;
        next_pref0 = 0;
    endtask

    task automatic test_single(input logic id, input logic [31:0] a, input logic [4:0] s,
                               input logic [1:0] t, input string name);
        logic [31:0] exp_r;
        logic [1:0]  exp_g;
        exp_r = ref_shift(a, s, t);
        exp_g = id ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        bus0.resp_ready = 1'b1;
        if (id) drive_req1(a, s, t); else drive_req0(a, s, t);
        bus0.req_valid = exp_g;
        @(negedge clk);
        checks++;
        if (bus0.req_ready !== exp_g) begin
            errors++;
            $display("FAIL %s_grant: got %b want %b", name, bus0.req_ready, exp_g);
        end
        @(posedge clk); #1;
        bus0.req_valid = 2'b00;
        next_pref0 = id ? 0 : 1;
        checks++;
        if ({bus0.sh_a, bus0.sh_shamt, bus0.sh_type} !== {a, s, t}) begin
            errors++;
            $display("FAIL %s_sh_regs: got %h/%0d/%b want %h/%0d/%b", name,
                     bus0.sh_a, bus0.sh_shamt, bus0.sh_type, a, s, t);
        end
        @(negedge clk);
        checks++;
        if (bus0.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_valid: got %b want 0", name, bus0.resp_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus0.resp_valid, bus0.resp_id, bus0.resp_r} !== {1'b1, id, exp_r}) begin
            errors++;
            $display("FAIL %s_resp: got v=%b id=%b r=%h want v=1 id=%b r=%h", name,
                     bus0.resp_valid, bus0.resp_id, bus0.resp_r, id, exp_r);
        end
        @(posedge clk); #1;
        checks++;
        if (bus0.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: resp_valid got %b want 0", name, bus0.resp_valid);
        end
    endtask

    task automatic test_directed;
        test_single(1'b0, 32'h8000_0000, 5'd4,  2'b10, "sra");
        test_single(1'b1, 32'h0000_0001, 5'd31, 2'b01, "sll");
        test_single(1'b1, 32'h8000_0000, 5'd1,  2'b11, "type11");
        test_single(1'b0, 32'hF000_000F, 5'd0,  2'b10, "zero_shamt");
    endtask

    task automatic test_random_singles;
        for (int i = 0; i < 8; i++)
            test_single(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                        2'($urandom_range(0, 3)), "rand");
    endtask

    task automatic test_round_robin;
        logic [1:0]  g, eg;
        logic [32:0] expv;
        int accepts;
        accepts = 0;
        exp_q.delete();
        @(posedge clk); #1;
        bus0.resp_ready = 1'b1;
        drive_req0($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        drive_req1($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        bus0.req_valid = 2'b11;
        for (int cyc = 0; cyc < 44; cyc++) begin
            @(negedge clk);
            if (bus0.resp_valid && bus0.resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_resp: unexpected response id=%b r=%h", bus0.resp_id, bus0.resp_r);
                end else begin
                    expv = exp_q.pop_front();
                    if ({bus0.resp_id, bus0.resp_r} !== expv) begin
                        errors++;
                        $display("FAIL rr_resp: got id=%b r=%h want id=%b r=%h",
                                 bus0.resp_id, bus0.resp_r, expv[32], expv[31:0]);
                    end
                end
            end
            g = bus0.req_ready;
            eg = 2'b00;
            if (g != 2'b00) begin
                if (bus0.req_valid == 2'b11) eg = (next_pref0 == 1) ? 2'b10 : 2'b01;
                else eg = bus0.req_valid;
                checks++;
                if (g !== eg) begin
                    errors++;
                    $display("FAIL rr_grant: got %b want %b at cycle %0d", g, eg, cyc);
                end
                accepts++;
                if (eg[1]) exp_q.push_back({1'b1, ref_shift(bus0.req1_a, bus0.req1_shamt, bus0.req1_type)});
                else       exp_q.push_back({1'b0, ref_shift(bus0.req0_a, bus0.req0_shamt, bus0.req0_type)});
                next_pref0 = eg[1] ? 0 : 1;
            end
            @(posedge clk); #1;
            if (cyc == 39) bus0.req_valid = 2'b00;
            else if (eg == 2'b10) drive_req1($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            else if (eg == 2'b01) drive_req0($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        checks++;
        if (accepts != 20) begin
            errors++;
            $display("FAIL rr_throughput: got %0d accepts want 20", accepts);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_fixed_priority;
        logic [1:0]  g, eg;
        logic [32:0] expv;
        int accepts;
        accepts = 0;
        exp_q.delete();
        @(posedge clk); #1;
        bus1.resp_ready = 1'b1;
        drive_rand_bus1(1'b0);
        drive_rand_bus1(1'b1);
        bus1.req_valid = 2'b11;
        for (int cyc = 0; cyc < 34; cyc++) begin
            @(negedge clk);
            if (bus1.resp_valid && bus1.resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL prio_resp: unexpected response id=%b r=%h", bus1.resp_id, bus1.resp_r);
                end else begin
                    expv = exp_q.pop_front();
                    if ({bus1.resp_id, bus1.resp_r} !== expv) begin
                        errors++;
                        $display("FAIL prio_resp: got id=%b r=%h want id=%b r=%h",
                                 bus1.resp_id, bus1.resp_r, expv[32], expv[31:0]);
                    end
                end
            end
            g = bus1.req_ready;
            eg = 2'b00;
            if (g != 2'b00) begin
                eg = bus1.req_valid[0] ? 2'b01 : bus1.req_valid;
                checks++;
                if (g !== eg) begin
                    errors++;
                    $display("FAIL prio_grant: got %b want %b at cycle %0d", g, eg, cyc);
                end
                accepts++;
                if (eg[1]) exp_q.push_back({1'b1, ref_shift(bus1.req1_a, bus1.req1_shamt, bus1.req1_type)});
                else       exp_q.push_back({1'b0, ref_shift(bus1.req0_a, bus1.req0_shamt, bus1.req0_type)});
            end
            @(posedge clk); #1;
            if (cyc == 19) bus1.req_valid = 2'b10;      // requester 0 drops out, 1 gets served
            else if (cyc == 27) bus1.req_valid = 2'b00;
            else if (eg != 2'b00) drive_rand_bus1(eg[1]);
        end
        checks++;
        if (accepts != 14) begin
            errors++;
            $display("FAIL prio_accepts: got %0d want 14", accepts);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL prio_drain: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a0, a1, e0, e1;
        logic [4:0]  s0, s1;
        logic [1:0]  t0, t1;
        a0 = $urandom; s0 = 5'($urandom_range(0, 31)); t0 = 2'($urandom_range(0, 3));
        a1 = $urandom; s1 = 5'($urandom_range(0, 31)); t1 = 2'($urandom_range(0, 3));
        e0 = ref_shift(a0, s0, t0);
        e1 = ref_shift(a1, s1, t1);
        @(posedge clk); #1;
        bus0.resp_ready = 1'b0;
        drive_req0(a0, s0, t0);
        bus0.req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (bus0.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_grant0: got %b want 01", bus0.req_ready);
        end
        @(posedge clk); #1;
        bus0.req_valid = 2'b00;
        next_pref0 = 1;
        @(posedge clk); #1;
        drive_req1(a1, s1, t1);
        bus0.req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus0.resp_valid, bus0.resp_id, bus0.resp_r, bus0.req_ready} !== {1'b1, 1'b0, e0, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold: got v=%b id=%b r=%h rdy=%b want v=1 id=0 r=%h rdy=00",
                         bus0.resp_valid, bus0.resp_id, bus0.resp_r, bus0.req_ready, e0);
            end
            @(posedge clk); #1;
        end
        bus0.resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus0.req_ready !== 2'b10 || bus0.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_b2b_grant: got rdy=%b v=%b want rdy=10 v=1", bus0.req_ready, bus0.resp_valid);
        end
        @(posedge clk); #1;
        bus0.req_valid = 2'b00;
        next_pref0 = 0;
        @(negedge clk);
        checks++;
        if (bus0.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_busy: resp_valid got %b want 0", bus0.resp_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus0.resp_valid, bus0.resp_id, bus0.resp_r} !== {1'b1, 1'b1, e1}) begin
            errors++;
            $display("FAIL bp_b2b_resp: got v=%b id=%b r=%h want v=1 id=1 r=%h",
                     bus0.resp_valid, bus0.resp_id, bus0.resp_r, e1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy;
        logic [31:0] a;
        a = $urandom;
        @(posedge clk); #1;
        bus0.resp_ready = 1'b1;
        drive_req0(a, 5'd3, 2'b00);
        bus0.req_valid = 2'b01;
        @(posedge clk); #1;
        rst = 1'b1;
        bus0.req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        next_pref0 = 0;
        checks++;
        if (bus0.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_valid: got %b want 0", bus0.resp_valid);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus0.resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_busy_no_resp: resp_valid got %b want 0", bus0.resp_valid);
            end
        end
        // After reset the tie must go to requester 0 again.
        @(posedge clk); #1;
        drive_req0(32'h1234_5678, 5'd8, 2'b01);
        drive_req1(32'hDEAD_BEEF, 5'd4, 2'b00);
        bus0.req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (bus0.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_rr_pointer: got %b want 01", bus0.req_ready);
        end
        @(posedge clk); #1;
        bus0.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.resp_valid, bus0.resp_id, bus0.resp_r} !== {1'b1, 1'b0, 32'h3456_7800}) begin
            errors++;
            $display("FAIL rst_after_resp: got v=%b id=%b r=%h want v=1 id=0 r=34567800",
                     bus0.resp_valid, bus0.resp_id, bus0.resp_r);
        end
        @(posedge clk); #1;
        test_single(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), "post_rst");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        next_pref0 = 0;
        rst = 1'b1;
        bus0.req_valid = 2'b00; bus0.resp_ready = 1'b1;
        bus1.req_valid = 2'b00; bus1.resp_ready = 1'b1;
        drive_req0('0, '0, '0);
        drive_req1('0, '0, '0);
        bus1.req0_a = '0; bus1.req0_shamt = '0; bus1.req0_type = '0;
        bus1.req1_a = '0; bus1.req1_shamt = '0; bus1.req1_type = '0;
        test_reset;
        test_directed;
        test_random_singles;
        test_round_robin;
        test_fixed_priority;
        test_back_to_back;
        test_reset_mid_busy;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational shifter instance (inputs a/shamt/type, output r) between two requesters.
  - Requester 0: EX-stage ALU shift path.
  - Requester 1: secondary client, e.g. a multi-cycle M-ext/CSR helper.
- Arbitrates, latches operands, drives the shifter, registers the result and returns it with a valid/ready handshake.
- One transaction in flight at a time.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 always wins.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid, bit i = requester i.
- req_ready  output  2  per-requester accept, bit i = requester i.
- req0_a  input  32  requester 0 operand.
- req0_shamt  input  5  requester 0 shift amount.
- req0_type  input  2  requester 0 shift type: 00 SRL, 01 SLL, 10 SRA, 11 SRL.
- req1_a  input  32  requester 1 operand.
- req1_shamt  input  5  requester 1 shift amount.
- req1_type  input  2  requester 1 shift type: same encoding as req0_type.
- sh_a  output  32  to shifter a.
- sh_shamt  output  5  to shifter shamt.
- sh_type  output  2  to shifter type.
- sh_r  input  32  from shifter r.
- resp_valid  output  1  result available.
- resp_id  output  1  requester that owns the result.
- resp_r  output  32  shifted result.
- resp_ready  input  1  consumer accepts result.

Behaviour:
- States:
  - IDLE: no transaction.
  - BUSY: operands latched, shifter evaluating.
  - DONE: result held.
- Reset (rst=1 at a clock edge):
  - state = IDLE.
  - req_ready = 2'b00 during reset cycle.
  - resp_valid = 0, resp_id = 0, resp_r = 0.
  - sh_a/sh_shamt/sh_type registers = 0.
  - RR pointer favours requester 0.
  - Reset mid-BUSY or mid-DONE abandons the transaction; no response is issued.
- Accept window:
  - Open in IDLE.
  - Open in DONE in the cycle resp_valid & resp_ready (back-to-back).
  - Closed in BUSY.
- Grant while window open:
  - req_ready = one-hot grant; at most one bit set, set only if that req_valid=1.
  - req_ready is combinational from req_valid and state.
- Arbitration when both valid:
  - PRIO_MODE=1: grant 0.
  - PRIO_MODE=0: grant the requester not granted last. The pointer updates only on an accepted transfer.
  - Single valid requester is always granted.
- Accept edge: operands, type and id latched into sh_* registers; go BUSY.
- BUSY (exactly one cycle):
  - sh_* stable.
  - At the edge: resp_r <= sh_r, resp_id <= latched id, resp_valid <= 1, go DONE.
- Latency: accept at edge k → resp_valid high from cycle after edge k+1, i.e. 2 cycles.
- DONE:
  - resp_valid/resp_r/resp_id held stable until resp_ready=1.
  - On handshake: accept a new request → BUSY, otherwise → IDLE with resp_valid=0.
- sh_* outputs are registered and change only on an accept edge. The block never interprets type; type 11 is passed unchanged.
- Requester holding req_valid without ready must keep operands stable; unaccepted requests carry no state.
- Throughput: one result per 2 cycles with resp_ready tied high.

Test Plan:
- Reset, then req_valid=01, a=0x80000000, shamt=4, type=10 → req_ready=01 same cycle. resp_valid 2 cycles later: resp_r=0xF8000000, resp_id=0.
- Req1 a=0x00000001, shamt=31, type=01 → resp_r=0x80000000, resp_id=1. Also type=11, a=0x80000000, shamt=1 → 0x40000000.
- PRIO_MODE=0, both valid continuously, resp_ready=1 → grants alternate 0,1,0,1; resp_id alternates; one accept per 2 cycles.
- PRIO_MODE=1, both valid → requester 0 granted every time; requester 1 starves while req_valid[0]=1.
- Backpressure: resp_ready=0 for 5 cycles in DONE → resp_r/resp_id stable, req_ready=00. Release with req pending → back-to-back accept in handshake cycle.
- Assert rst during BUSY → next cycle resp_valid=0, state IDLE. Following request completes normally with correct result.
